coprocessor0_regfile: RTL and testbench
=======================================

Name: coprocessor0_regfile

Overview:
- CP0 register file for the MIPS core; sits directly downstream of write-back and consumes the per-retire CP0 request (WBToCP0Data) plus exception detail.
- Holds Status, Cause, EPC, Count, Compare (and optionally BadVAddr).
- Produces MFC0 read data, the interrupt-pending flag and the exception/ERET redirect target for the fetch stage.

Parameters:
- EXCEPTION_VECTOR_NORMAL, 32'h8000_0180, handler address when Status.BEV=0.
- EXCEPTION_VECTOR_BOOT, 32'hBFC0_0380, handler address when Status.BEV=1.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  reset, asynchronous, active-low.
- wb_to_cp0  in  43  WBToCP0Data: {address_register[4:0], address_select[2:0], write_enabled, write_data[31:0], exception_valid, eret_flish}.
- wb_exception_code  in  5  ExcCode of the retiring exception.
- wb_in_delay_slot  in  1  retiring instruction is in a branch delay slot.
- wb_pc  in  32  PC of the retiring instruction.
- wb_bad_vaddr  in  32  faulting address (AdEL/AdES).
- hardware_interrupt  in  6  external interrupt lines, level.
- read_register  in  5  MFC0 register number.
- read_select  in  3  MFC0 select.
- read_data  out  32  MFC0 result, combinational.
- interrupt_pending  out  1  unmasked interrupt request to decode.
- redirect_valid  out  1  registered; flush and redirect fetch.
- redirect_target  out  32  registered redirect PC.

Behaviour:
- Reset values:
  - Status = 0 except BEV = 1.
  - Cause = 0, EPC = 0, Count = 0, Compare = 0, BadVAddr = 0, count tick = 0.
  - redirect_valid = 0, redirect_target = 0.
- Priority per cycle: exception_valid > eret_flish > write_enabled. Lower-priority requests in the same cycle are ignored, except that Count ticking and hardware_interrupt sampling always proceed.
- Exception entry (exception_valid = 1):
  - If Status.EXL = 0: EPC ← wb_pc − 4 when wb_in_delay_slot, else wb_pc; Cause.BD ← wb_in_delay_slot.
  - If Status.EXL = 1: EPC and BD are unchanged.
  - Always: Cause.ExcCode ← wb_exception_code; Status.EXL ← 1.
  - Next cycle: redirect_valid = 1, redirect_target = BEV ? EXCEPTION_VECTOR_BOOT : EXCEPTION_VECTOR_NORMAL.
- ERET (eret_flish = 1): Status.EXL ← 0. Next cycle: redirect_valid = 1, redirect_target = EPC value before any same-cycle update.
- redirect_valid is a one-cycle pulse. Back-to-back events produce back-to-back pulses.
- MTC0 (write_enabled = 1, select = 0). Writable fields:
  - Status: IM[7:0], EXL, IE. BEV is read-only after reset.
  - Cause: IP[1:0] (software interrupts) only.
  - EPC: full 32 bits.
  - Count: full 32 bits; also clears the count tick.
  - Compare: full 32 bits; also clears Cause.TI.
  - Writes to any other register/select are dropped.
- Count:
  - Tick toggles every cycle; Count increments when tick = 1 (half core rate); wraps from FFFF_FFFF to 0.
  - An MTC0 write to Count in the same cycle wins over the increment.
- Timer interrupt: Cause.TI ← 1 on the cycle Count == Compare (registered compare of current values). TI stays set until Compare is written. A Compare write and a match in the same cycle leave TI = 0.
- Cause.IP[7:2] ← hardware_interrupt every cycle (one-cycle registered sample).
- Effective IP7 = IP[7] | TI.
- interrupt_pending = Status.IE & ~Status.EXL & |({IP7, IP[6:0]} & IM), combinational from registers.
- read_data:
  - Returns a register only for select = 0 and a known register number; all other reads return 0.
  - Zero fields read as 0.
  - MFC0 reads the pre-write value (no bypass).
- Reset mid-operation: all state returns to the reset values immediately; a pending redirect pulse is cancelled.

Optional Feature:
- Macro: COPROCESSOR0_BADVADDR_EN.
- Defined: BadVAddr (reg 8, sel 0) exists and is read-only to MTC0. On exception with ExcCode 4 (AdEL) or 5 (AdES), BadVAddr ← wb_bad_vaddr, independent of EXL.
- Undefined: no BadVAddr storage; reg 8 reads 0; wb_bad_vaddr is ignored.

Decomposition:
- coprocessor0_params gains:
  - register number constants: STATUS = 12, CAUSE = 13, EPC = 14, COUNT = 9, COMPARE = 11, BADVADDR = 8;
  - an ExcCode enum: INT = 0, ADEL = 4, ADES = 5, SYS = 8, BP = 9, RI = 10, OV = 12;
  - the two vector constants.
- Reuse the StatusData and CauseData layouts from coprocessor0_params for the register storage.
- One sub-module, coprocessor0_timer: owns Count, Compare, the tick and TI; takes the write strobes; outputs the values and TI.

Test Plan:
- Reset release → read Status = 0040_0000 (BEV); Cause, EPC, Count = 0; redirect_valid = 0.
- Exception ExcCode 8, wb_pc 0xBFC0_0100, delay slot = 1 → EPC = 0xBFC0_00FC, BD = 1, EXL = 1; next cycle redirect to 0xBFC0_0380.
- Second exception while EXL = 1, pc 0x8000_0200 → EPC unchanged; then ERET → EXL = 0, redirect to 0xBFC0_00FC.
- MTC0 Compare = 10, Count = 0, IM7 = 1, IE = 1 → TI and interrupt_pending assert once Count reaches 10 (about 20 cycles); MTC0 Compare clears both.
- hardware_interrupt = 6'b000001, IM2 = 1, IE = 1, EXL = 0 → interrupt_pending one cycle later. Setting EXL = 1 drops it; IM2 = 0 masks it.
- Same-cycle exception_valid + eret_flish + MTC0 to EPC → only exception applied; EPC = exception PC.

Source files
------------

// File: rtl/coprocessor0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, vectors and packed layouts.
// The optional BadVAddr register is enabled with COPROCESSOR0_BADVADDR_EN.
package coprocessor0_params;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   localparam logic [31:0] CP0_VECTOR_NORMAL = 32'h8000_0180;
   localparam logic [31:0] CP0_VECTOR_BOOT   = 32'hBFC0_0380;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_t;

   typedef struct packed {
      logic [8:0] zero_31_23;
      logic       bev;
      logic [5:0] zero_21_16;
      logic [7:0] im;
      logic [5:0] zero_7_2;
      logic       exl;
      logic       ie;
   } status_data_t;

   typedef struct packed {
      logic        bd;
      logic        ti;
      logic [13:0] zero_29_16;
      logic [7:0]  ip;
      logic        zero_7;
      logic [4:0]  exc_code;
      logic [1:0]  zero_1_0;
   } cause_data_t;

   typedef struct packed {
      logic [4:0]  address_register;
      logic [2:0]  address_select;
      logic        write_enabled;
      logic [31:0] write_data;
      logic        exception_valid;
      logic        eret_flish;
   } wb_to_cp0_data_t;

endpackage

// File: rtl/coprocessor0_regfile_timer.sv
// CP0 Count/Compare pair: half-rate counter and sticky timer interrupt flag.
module coprocessor0_timer
   import coprocessor0_params::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] write_data,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_interrupt
);

   logic [31:0] count_reg, count_next;
   logic [31:0] compare_reg, compare_next;
   logic        tick_reg, tick_next;
   logic        ti_reg, ti_next;

   always_comb begin
      tick_next    = ~tick_reg;
      count_next   = tick_reg ? count_reg + 32'd1 : count_reg;
      compare_next = compare_reg;
      ti_next      = ti_reg;
      if (count_we) begin
         count_next = write_data;
         tick_next  = 1'b0;
      end
      // A Compare write acknowledges the interrupt even if a match lands the same cycle
      if (compare_we) begin
         compare_next = write_data;
         ti_next      = 1'b0;
      end else if (count_reg == compare_reg) begin
         ti_next = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_reg   <= '0;
         compare_reg <= '0;
         tick_reg    <= 1'b0;
         ti_reg      <= 1'b0;
      end else begin
         count_reg   <= count_next;
         compare_reg <= compare_next;
         tick_reg    <= tick_next;
         ti_reg      <= ti_next;
      end
   end

   assign count           = count_reg;
   assign compare         = compare_reg;
   assign timer_interrupt = ti_reg;

endmodule

// File: rtl/coprocessor0_regfile.sv
// CP0 register file: Status/Cause/EPC plus timer, MFC0 read port and exception/ERET redirect.
// Define COPROCESSOR0_BADVADDR_EN to add the read-only BadVAddr register (reg 8).
module coprocessor0_regfile
   import coprocessor0_params::*;
#(
   parameter logic [31:0] EXCEPTION_VECTOR_NORMAL = CP0_VECTOR_NORMAL,
   parameter logic [31:0] EXCEPTION_VECTOR_BOOT   = CP0_VECTOR_BOOT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [42:0] wb_to_cp0,
   input  logic [4:0]  wb_exception_code,
   input  logic        wb_in_delay_slot,
   input  logic [31:0] wb_pc,
   input  logic [31:0] wb_bad_vaddr,
   input  logic [5:0]  hardware_interrupt,
   input  logic [4:0]  read_register,
   input  logic [2:0]  read_select,
   output logic [31:0] read_data,
   output logic        interrupt_pending,
   output logic        redirect_valid,
   output logic [31:0] redirect_target
);

   wb_to_cp0_data_t req;
   status_data_t    status_reg, status_next, wr_status;
   cause_data_t     cause_reg, cause_next, cause_read;
   logic [31:0]     epc_reg, epc_next;
   logic            redirect_valid_reg, redirect_valid_next;
   logic [31:0]     redirect_target_reg, redirect_target_next;
   logic            mtc0_active, count_we, compare_we;
   logic [31:0]     timer_count, timer_compare;
   logic            timer_ti;
   logic [7:0]      ip_effective;

   assign req       = wb_to_cp0_data_t'(wb_to_cp0);
   assign wr_status = status_data_t'(req.write_data);

   // MTC0 only lands when nothing of higher priority retires in the same cycle
   assign mtc0_active = req.write_enabled & ~req.exception_valid & ~req.eret_flish
                        & (req.address_select == 3'd0);
   assign count_we    = mtc0_active && (req.address_register == REG_COUNT);
   assign compare_we  = mtc0_active && (req.address_register == REG_COMPARE);

   coprocessor0_timer u_timer (
      .clock           (clock),
      .reset_n         (reset_n),
      .count_we        (count_we),
      .compare_we      (compare_we),
      .write_data      (req.write_data),
      .count           (timer_count),
      .compare         (timer_compare),
      .timer_interrupt (timer_ti)
   );

   always_comb begin
      status_next          = status_reg;
      cause_next           = cause_reg;
      epc_next             = epc_reg;
      redirect_valid_next  = 1'b0;
      redirect_target_next = redirect_target_reg;
      cause_next.ip[7:2]   = hardware_interrupt;
      if (req.exception_valid) begin
         if (!status_reg.exl) begin
            epc_next      = wb_in_delay_slot ? wb_pc - 32'd4 : wb_pc;
            cause_next.bd = wb_in_delay_slot;
         end
         cause_next.exc_code  = wb_exception_code;
         status_next.exl      = 1'b1;
         redirect_valid_next  = 1'b1;
         redirect_target_next = status_reg.bev ? EXCEPTION_VECTOR_BOOT : EXCEPTION_VECTOR_NORMAL;
      end else if (req.eret_flish) begin
         status_next.exl      = 1'b0;
         redirect_valid_next  = 1'b1;
         redirect_target_next = epc_reg;
      end else if (mtc0_active) begin
         case (req.address_register)
            REG_STATUS: begin
               status_next.im  = wr_status.im;
               status_next.exl = wr_status.exl;
               status_next.ie  = wr_status.ie;
            end
            REG_CAUSE: cause_next.ip[1:0] = req.write_data[9:8];
            REG_EPC:   epc_next = req.write_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         status_reg          <= '0;
         status_reg.bev      <= 1'b1;
         cause_reg           <= '0;
         epc_reg             <= '0;
         redirect_valid_reg  <= 1'b0;
         redirect_target_reg <= '0;
      end else begin
         status_reg          <= status_next;
         cause_reg           <= cause_next;
         epc_reg             <= epc_next;
         redirect_valid_reg  <= redirect_valid_next;
         redirect_target_reg <= redirect_target_next;
      end
   end

`ifdef COPROCESSOR0_BADVADDR_EN
   logic [31:0] badvaddr_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         badvaddr_reg <= '0;
      end else if (req.exception_valid &&
                   (wb_exception_code == EXC_ADEL || wb_exception_code == EXC_ADES)) begin
         badvaddr_reg <= wb_bad_vaddr;
      end
   end
`else
   logic unused_bad_vaddr;
   assign unused_bad_vaddr = ^wb_bad_vaddr;
`endif

   always_comb begin
      cause_read    = cause_reg;
      cause_read.ti = timer_ti;
   end

   always_comb begin
      read_data = '0;
      if (read_select == 3'd0) begin
         case (read_register)
            REG_STATUS:   read_data = status_reg;
            REG_CAUSE:    read_data = cause_read;
            REG_EPC:      read_data = epc_reg;
            REG_COUNT:    read_data = timer_count;
            REG_COMPARE:  read_data = timer_compare;
`ifdef COPROCESSOR0_BADVADDR_EN
            REG_BADVADDR: read_data = badvaddr_reg;
`endif
            default:      read_data = '0;
         endcase
      end
   end

   // The timer flag shares the IP7 slot with the external line
   assign ip_effective      = {cause_reg.ip[7] | timer_ti, cause_reg.ip[6:0]};
   assign interrupt_pending = status_reg.ie & ~status_reg.exl & |(ip_effective & status_reg.im);
   assign redirect_valid    = redirect_valid_reg;
   assign redirect_target   = redirect_target_reg;

endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Scenario bench for coprocessor0_regfile; redirect targets are scoreboarded through a queue.
module tb_coprocessor0_regfile;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [42:0] wb_to_cp0 = '0;
   logic [4:0]  wb_exception_code = '0;
   logic        wb_in_delay_slot = 1'b0;
   logic [31:0] wb_pc = '0;
   logic [31:0] wb_bad_vaddr = '0;
   logic [5:0]  hardware_interrupt = '0;
   logic [4:0]  read_register = '0;
   logic [2:0]  read_select = '0;
   logic [31:0] read_data;
   logic        interrupt_pending;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   int check_count = 0;
   int pass_count  = 0;
   logic [31:0] sb[$];

   localparam logic [4:0] R_COUNT = 5'd9, R_COMPARE = 5'd11, R_STATUS = 5'd12;
   localparam logic [4:0] R_CAUSE = 5'd13, R_EPC = 5'd14;

   coprocessor0_regfile dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .wb_to_cp0          (wb_to_cp0),
      .wb_exception_code  (wb_exception_code),
      .wb_in_delay_slot   (wb_in_delay_slot),
      .wb_pc              (wb_pc),
      .wb_bad_vaddr       (wb_bad_vaddr),
      .hardware_interrupt (hardware_interrupt),
      .read_register      (read_register),
      .read_select        (read_select),
      .read_data          (read_data),
      .interrupt_pending  (interrupt_pending),
      .redirect_valid     (redirect_valid),
      .redirect_target    (redirect_target)
   );

   always #5 clock = ~clock;

   // Called at a negedge; the request is captured by the following posedge.
   task automatic issue(input logic [4:0] r, input logic [2:0] s, input logic we,
                        input logic [31:0] d, input logic exc, input logic eret,
                        input logic [4:0] code, input logic ds, input logic [31:0] pc);
      wb_to_cp0         = {r, s, we, d, exc, eret};
      wb_exception_code = code;
      wb_in_delay_slot  = ds;
      wb_pc             = pc;
      wb_bad_vaddr      = pc ^ 32'h5A5A_0000;
      $display("txn reg=%0d sel=%0d we=%0b data=%h exc=%0b eret=%0b code=%0d ds=%0b pc=%h",
               r, s, we, d, exc, eret, code, ds, pc);
      @(negedge clock);
      wb_to_cp0 = '0;
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
      issue(r, 3'd0, 1'b1, d, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
   endtask

   task automatic mfc0(input logic [4:0] r, input logic [2:0] s, output logic [31:0] v);
      read_register = r;
      read_select   = s;
      #1;
      v = read_data;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      repeat (2) @(negedge clock);
      mfc0(R_STATUS, 3'd0, v);
      check_count++; if (v !== 32'h0040_0000) $display("FAIL reset_status got %h want %h", v, 32'h0040_0000); else pass_count++;
      mfc0(R_CAUSE, 3'd0, v);
      check_count++; if (v !== 32'h0) $display("FAIL reset_cause got %h want 0", v); else pass_count++;
      mfc0(R_EPC, 3'd0, v);
      check_count++; if (v !== 32'h0) $display("FAIL reset_epc got %h want 0", v); else pass_count++;
      mfc0(R_COUNT, 3'd0, v);
      check_count++; if (v !== 32'h0) $display("FAIL reset_count got %h want 0", v); else pass_count++;
      check_count++; if (redirect_valid !== 1'b0 || redirect_target !== 32'h0) $display("FAIL reset_redirect got %b/%h want 0/0", redirect_valid, redirect_target); else pass_count++;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_exception;
      logic [31:0] v, e;
      sb.push_back(32'hBFC0_0380);
      issue(5'd0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b0, 5'd8, 1'b1, 32'hBFC0_0100);
      e = sb.pop_front();
      check_count++; if (redirect_valid !== 1'b1 || redirect_target !== e) $display("FAIL exc_redirect got %b/%h want 1/%h", redirect_valid, redirect_target, e); else pass_count++;
      mfc0(R_EPC, 3'd0, v);
      check_count++; if (v !== 32'hBFC0_00FC) $display("FAIL exc_epc got %h want %h", v, 32'hBFC0_00FC); else pass_count++;
      mfc0(R_CAUSE, 3'd0, v);
      check_count++; if ((v & 32'h8000_007C) !== 32'h8000_0020) $display("FAIL exc_cause_bd_code got %h want %h", v & 32'h8000_007C, 32'h8000_0020); else pass_count++;
      mfc0(R_STATUS, 3'd0, v);
      check_count++; if (v !== 32'h0040_0002) $display("FAIL exc_status got %h want %h", v, 32'h0040_0002); else pass_count++;
      @(negedge clock);
      check_count++; if (redirect_valid !== 1'b0) $display("FAIL exc_pulse_end got %b want 0", redirect_valid); else pass_count++;
   endtask

   task automatic test_nested_eret;
      logic [31:0] v, e;
      sb.push_back(32'hBFC0_0380);
      issue(5'd0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b0, 5'd12, 1'b0, 32'h8000_0200);
      e = sb.pop_front();
      check_count++; if (redirect_valid !== 1'b1 || redirect_target !== e) $display("FAIL nested_redirect got %b/%h want 1/%h", redirect_valid, redirect_target, e); else pass_count++;
      mfc0(R_EPC, 3'd0, v);
      check_count++; if (v !== 32'hBFC0_00FC) $display("FAIL nested_epc got %h want %h", v, 32'hBFC0_00FC); else pass_count++;
      mfc0(R_CAUSE, 3'd0, v);
      check_count++; if ((v & 32'h8000_007C) !== 32'h8000_0030) $display("FAIL nested_cause got %h want %h", v & 32'h8000_007C, 32'h8000_0030); else pass_count++;
      sb.push_back(32'hBFC0_00FC);
      issue(5'd0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
      e = sb.pop_front();
      check_count++; if (redirect_valid !== 1'b1 || redirect_target !== e) $display("FAIL eret_redirect got %b/%h want 1/%h", redirect_valid, redirect_target, e); else pass_count++;
      mfc0(R_STATUS, 3'd0, v);
      check_count++; if (v !== 32'h0040_0000) $display("FAIL eret_status got %h want %h", v, 32'h0040_0000); else pass_count++;
   endtask

   task automatic test_timer;
      logic [31:0] v;
      int waited;
      mtc0(R_STATUS, 32'h0000_8001);
      mtc0(R_COUNT, 32'h0);
      mtc0(R_COMPARE, 32'd10);
      mfc0(R_CAUSE, 3'd0, v);
      check_count++; if (v[30] !== 1'b0 || interrupt_pending !== 1'b0) $display("FAIL timer_armed got ti=%b pend=%b want 0/0", v[30], interrupt_pending); else pass_count++;
      waited = 0;
      while (!interrupt_pending && waited < 60) begin
         @(negedge clock);
         waited++;
      end
      check_count++; if (waited !== 20) $display("FAIL timer_latency got %0d want 20 cycles", waited); else pass_count++;
      mfc0(R_CAUSE, 3'd0, v);
      check_count++; if (v[30] !== 1'b1) $display("FAIL timer_ti got %b want 1", v[30]); else pass_count++;
      mfc0(R_COUNT, 3'd0, v);
      check_count++; if (v !== 32'd10) $display("FAIL timer_count got %h want %h", v, 32'd10); else pass_count++;
      mtc0(R_COMPARE, 32'h0000_1000);
      mfc0(R_CAUSE, 3'd0, v);
      check_count++; if (v[30] !== 1'b0 || interrupt_pending !== 1'b0) $display("FAIL timer_clear got ti=%b pend=%b want 0/0", v[30], interrupt_pending); else pass_count++;
   endtask

   task automatic test_hw_interrupt;
      mtc0(R_STATUS, 32'h0000_0401);
      hardware_interrupt = 6'b000001;
      #1;
      check_count++; if (interrupt_pending !== 1'b0) $display("FAIL hw_before_sample got %b want 0", interrupt_pending); else pass_count++;
      @(negedge clock);
      check_count++; if (interrupt_pending !== 1'b1) $display("FAIL hw_pending got %b want 1", interrupt_pending); else pass_count++;
      mtc0(R_STATUS, 32'h0000_0403);
      check_count++; if (interrupt_pending !== 1'b0) $display("FAIL hw_exl_block got %b want 0", interrupt_pending); else pass_count++;
      mtc0(R_STATUS, 32'h0000_0001);
      check_count++; if (interrupt_pending !== 1'b0) $display("FAIL hw_im_mask got %b want 0", interrupt_pending); else pass_count++;
      mtc0(R_STATUS, 32'h0000_0401);
      check_count++; if (interrupt_pending !== 1'b1) $display("FAIL hw_unmask got %b want 1", interrupt_pending); else pass_count++;
      hardware_interrupt = 6'b000000;
      @(negedge clock);
      check_count++; if (interrupt_pending !== 1'b0) $display("FAIL hw_release got %b want 0", interrupt_pending); else pass_count++;
   endtask

   task automatic test_priority;
      logic [31:0] v, e;
      sb.push_back(32'hBFC0_0380);
      issue(R_EPC, 3'd0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 5'd10, 1'b0, 32'h8000_0400);
      e = sb.pop_front();
      check_count++; if (redirect_valid !== 1'b1 || redirect_target !== e) $display("FAIL prio_redirect got %b/%h want 1/%h", redirect_valid, redirect_target, e); else pass_count++;
      mfc0(R_EPC, 3'd0, v);
      check_count++; if (v !== 32'h8000_0400) $display("FAIL prio_epc got %h want %h", v, 32'h8000_0400); else pass_count++;
      mfc0(R_STATUS, 3'd0, v);
      check_count++; if (v !== 32'h0040_0403) $display("FAIL prio_status got %h want %h", v, 32'h0040_0403); else pass_count++;
      mfc0(R_CAUSE, 3'd0, v);
      check_count++; if ((v & 32'h8000_007C) !== 32'h0000_0028) $display("FAIL prio_cause got %h want %h", v & 32'h8000_007C, 32'h0000_0028); else pass_count++;
   endtask

   task automatic test_back_to_back;
      logic [31:0] e;
      sb.push_back(32'hBFC0_0380);
      issue(5'd0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b0, 5'd9, 1'b0, 32'h8000_0500);
      e = sb.pop_front();
      check_count++; if (redirect_valid !== 1'b1 || redirect_target !== e) $display("FAIL b2b_first got %b/%h want 1/%h", redirect_valid, redirect_target, e); else pass_count++;
      sb.push_back(32'h8000_0400);
      issue(5'd0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
      e = sb.pop_front();
      check_count++; if (redirect_valid !== 1'b1 || redirect_target !== e) $display("FAIL b2b_second got %b/%h want 1/%h", redirect_valid, redirect_target, e); else pass_count++;
      @(negedge clock);
      check_count++; if (redirect_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", redirect_valid); else pass_count++;
   endtask

   task automatic test_mtc0_misc;
      logic [31:0] v;
      mtc0(R_CAUSE, 32'hFFFF_FFFF);
      mfc0(R_CAUSE, 3'd0, v);
      check_count++; if (v !== 32'h0000_0324) $display("FAIL cause_write_mask got %h want %h", v, 32'h0000_0324); else pass_count++;
      mtc0(R_STATUS, 32'hFFFF_FFFF);
      mfc0(R_STATUS, 3'd0, v);
      check_count++; if (v !== 32'h0040_FF03) $display("FAIL status_write_mask got %h want %h", v, 32'h0040_FF03); else pass_count++;
      mfc0(R_STATUS, 3'd1, v);
      check_count++; if (v !== 32'h0) $display("FAIL read_sel1 got %h want 0", v); else pass_count++;
      issue(5'd8, 3'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
      mfc0(5'd8, 3'd0, v);
      check_count++; if (v !== 32'h0) $display("FAIL badvaddr_read got %h want 0", v); else pass_count++;
      issue(R_EPC, 3'd2, 1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
      mfc0(R_EPC, 3'd0, v);
      check_count++; if (v !== 32'h8000_0400) $display("FAIL epc_sel2_drop got %h want %h", v, 32'h8000_0400); else pass_count++;
      mtc0(R_STATUS, 32'h0000_0300);
      check_count++; if (interrupt_pending !== 1'b0) $display("FAIL sw_ie_off got %b want 0", interrupt_pending); else pass_count++;
      mtc0(R_STATUS, 32'h0000_0301);
      check_count++; if (interrupt_pending !== 1'b1) $display("FAIL sw_pending got %b want 1", interrupt_pending); else pass_count++;
      mtc0(R_CAUSE, 32'h0);
      check_count++; if (interrupt_pending !== 1'b0) $display("FAIL sw_clear got %b want 0", interrupt_pending); else pass_count++;
   endtask

   task automatic test_count_wrap;
      logic [31:0] v;
      mtc0(R_COUNT, 32'hFFFF_FFFF);
      mfc0(R_COUNT, 3'd0, v);
      check_count++; if (v !== 32'hFFFF_FFFF) $display("FAIL wrap_load got %h want %h", v, 32'hFFFF_FFFF); else pass_count++;
      repeat (2) @(negedge clock);
      mfc0(R_COUNT, 3'd0, v);
      check_count++; if (v !== 32'h0) $display("FAIL wrap_zero got %h want 0", v); else pass_count++;
   endtask

   task automatic test_reset_mid;
      logic [31:0] v;
      wb_to_cp0 = {5'd0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b0};
      wb_exception_code = 5'd10;
      wb_pc = 32'h8000_0600;
      $display("txn exception then reset while redirect pending");
      @(posedge clock);
      #1;
      wb_to_cp0 = '0;
      check_count++; if (redirect_valid !== 1'b1) $display("FAIL midreset_pre got %b want 1", redirect_valid); else pass_count++;
      reset_n = 1'b0;
      #1;
      check_count++; if (redirect_valid !== 1'b0 || redirect_target !== 32'h0) $display("FAIL midreset_cancel got %b/%h want 0/0", redirect_valid, redirect_target); else pass_count++;
      mfc0(R_STATUS, 3'd0, v);
      check_count++; if (v !== 32'h0040_0000) $display("FAIL midreset_status got %h want %h", v, 32'h0040_0000); else pass_count++;
      mfc0(R_EPC, 3'd0, v);
      check_count++; if (v !== 32'h0) $display("FAIL midreset_epc got %h want 0", v); else pass_count++;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_exception();
      test_nested_eret();
      test_timer();
      test_hw_interrupt();
      test_priority();
      test_back_to_back();
      test_mtc0_misc();
      test_count_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
